logic_result_accumulator: RTL and testbench
===========================================

Name: logic_result_accumulator

Overview:
- Downstream consumer of the 8-bit OR/AND selector result stream.
- Folds a frame of selector results into one word, using the same per-frame OR/AND mode that drove the selector.
- Presents the folded word, its popcount and the beat count on a valid/ready output held in a one-entry output register.
- Sits between the logic-mux stage and result readout/IO.

Parameters:
- WIDTH, 8, data width of input beats and folded result.
- MAX_BEATS, 16, maximum beats per frame; a frame is force-closed when this count is reached (legal range 2..255).
- CNT_W, $clog2(MAX_BEATS+1), width of beat counters (derived, not overridden).
- POP_W, $clog2(WIDTH+1), width of popcount output (derived).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  selector result beat.
- in_mode  input  1  1 = OR-fold, 0 = AND-fold; sampled only on the first beat of a frame.
- in_last  input  1  marks the final beat of a frame.
- out_valid  output  1  folded result available.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  folded result.
- out_pop  output  POP_W  number of 1 bits in out_data.
- out_beats  output  CNT_W  beats folded into out_data.
- out_mode  output  1  fold mode of the frame.
- out_trunc  output  1  frame closed by MAX_BEATS, not by in_last.
- busy  output  1  frame open (state ACCUM).

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, accumulator=0, count=0.
  - All out_* registers = 0; busy=0.
  - in_ready forced 0 while rst is high.
  - Reset mid-frame discards the partial frame; reset while out_valid=1 drops the held result.
- Handshake:
  - A beat transfers when in_valid & in_ready.
  - A result transfers when out_valid & out_ready.
  - in_ready = ~rst & (~out_valid | out_ready), combinational from out_ready.
- States:
  - IDLE, on accepted beat:
    - acc <= in_data; mode_q <= in_mode; count <= 1.
    - If in_last: close the frame this cycle with result = in_data, beats = 1; stay in IDLE.
    - Otherwise go to ACCUM.
  - ACCUM, on accepted beat:
    - next = mode_q ? (acc | in_data) : (acc & in_data).
    - in_mode is ignored.
    - Close if in_last, or if count+1 == MAX_BEATS; closing returns to IDLE.
    - Otherwise acc <= next; count <= count+1.
  - No accepted beat in either state: hold all state.
- Close (same edge as the closing beat):
  - out_data <= next (the result including the closing beat).
  - out_pop <= popcount(next).
  - out_beats <= count+1.
  - out_mode <= mode_q (in_mode for a 1-beat frame).
  - out_trunc <= ~in_last.
  - out_valid <= 1.
- Latency: result is visible the cycle after the closing beat is accepted.
- Output register:
  - Holds its value until popped.
  - A pop with no simultaneous close clears out_valid.
  - Pop and close on the same edge: new result loads and out_valid stays 1.
- Back-pressure: while out_valid=1 & out_ready=0, in_ready=0, and accumulation stalls in both states.
- Edge cases:
  - in_last on the MAX_BEATS-th beat: out_trunc=0.
  - Frame of exactly MAX_BEATS beats without in_last: truncated, out_trunc=1; the following beat starts a new frame.
- busy = (state==ACCUM).

Test Plan:
- OR frame: mode=1, beats 0x01, 0x10, 0x80 (last on the third) -> out_data=0x91, out_pop=3, out_beats=3, out_mode=1, out_trunc=0, out_valid one cycle after the last beat.
- AND frame with mid-frame mode toggle: mode=0 on the first beat, 1 on later beats; beats 0xFF, 0xF0, 0x3C (last) -> out_data=0x30, out_pop=2, out_mode=0.
- Single-beat frame: in_data=0xA5, in_last=1, mode=1 -> out_data=0xA5, out_beats=1, out_pop=4; busy never asserts.
- Truncation: MAX_BEATS=16, 17 OR beats of 0x00 with no in_last except on beat 17 -> first result out_beats=16, out_trunc=1; second result out_beats=1, out_trunc=0.
- Back-pressure: out_ready=0 with a result held -> in_ready=0 and the next frame's beats are not consumed. Then raise out_ready while a closing beat is presented -> back-to-back pop and load, out_valid stays 1, no beat lost or duplicated.
- Reset mid-frame after 2 beats and with out_valid=1 -> all outputs 0, busy=0. The next frame folds from scratch (beat 0x0F alone, last -> 0x0F).

Source files
------------

// File: rtl/logic_result_accumulator.sv
// logic_result_accumulator
// Folds a frame of OR/AND selector result beats into one word and presents the
// folded word, its popcount, the beat count, the fold mode and a truncation flag
// through a one-entry valid/ready output register.
module logic_result_accumulator #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1),
  localparam int POP_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [POP_W-1:0] out_pop,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_mode,
  output logic             out_trunc,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;

  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_next;
  logic             mode_eff;
  logic             accept;
  logic             close;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [POP_W-1:0] out_pop_q;
  logic [CNT_W-1:0] out_beats_q;
  logic             out_mode_q;
  logic             out_trunc_q;

  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      p = p + POP_W'(v[i]);
    end
    return p;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any accepted beat opens a frame unless it also closes it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = close ? IDLE : ACCUM;
    end
  end

  // Handshake outputs and frame-open indicator.
  always_comb begin
    in_ready = ~rst & (~out_valid_q | out_ready);
    busy     = (state_q == ACCUM);
  end

  // Fold, beat count and close decision for the beat currently presented.
  always_comb begin
    accept   = in_valid & in_ready;
    fold     = in_data;
    cnt_next = CNT_W'(1);
    mode_eff = in_mode;
    if (state_q == ACCUM) begin
      fold     = mode_q ? (acc_q | in_data) : (acc_q & in_data);
      cnt_next = cnt_q + CNT_W'(1);
      mode_eff = mode_q;
    end
    close = accept & (in_last | (cnt_next == CNT_W'(MAX_BEATS)));
  end

  // Accumulator; its contents are don't-care in IDLE so it simply tracks every accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      acc_q  <= fold;
      cnt_q  <= cnt_next;
      mode_q <= mode_eff;
    end
  end

  // Output register: a close loads (even while popping), a bare pop only clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pop_q   <= '0;
      out_beats_q <= '0;
      out_mode_q  <= 1'b0;
      out_trunc_q <= 1'b0;
    end else if (close) begin
      out_valid_q <= 1'b1;
      out_data_q  <= fold;
      out_pop_q   <= popcount(fold);
      out_beats_q <= cnt_next;
      out_mode_q  <= mode_eff;
      out_trunc_q <= ~in_last;
    end else if (out_valid_q & out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_pop   = out_pop_q;
  assign out_beats = out_beats_q;
  assign out_mode  = out_mode_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_logic_result_accumulator.sv
// Testbench for logic_result_accumulator: directed scenarios plus random traffic,
// all checked against a frame-level reference model built from beat queues.
module tb_logic_result_accumulator;

  localparam int W  = 8;
  localparam int MB = 16;
  localparam int CW = $clog2(MB + 1);
  localparam int PW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [PW-1:0] out_pop;
  logic [CW-1:0] out_beats;
  logic          out_mode;
  logic          out_trunc;
  logic          busy;

  always #5 clk = ~clk;

  logic_result_accumulator #(
    .WIDTH    (W),
    .MAX_BEATS(MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_pop  (out_pop),
    .out_beats(out_beats),
    .out_mode (out_mode),
    .out_trunc(out_trunc),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: beats of the open frame, and the held result.
  logic [W-1:0] fq[$];
  bit           fmode;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_pop;
  int           m_beats;
  bit           m_mode;
  bit           m_trunc;

  task automatic model_step(input bit r, input bit iv, input logic [W-1:0] d,
                            input bit m, input bit l, input bit ordy);
    bit acc, pop, closed;
    logic [W-1:0] res;
    if (r) begin
      fq.delete();
      m_valid = 0; m_data = '0; m_pop = 0; m_beats = 0; m_mode = 0; m_trunc = 0;
    end else begin
      acc    = iv && (!m_valid || ordy);
      pop    = m_valid && ordy;
      closed = 0;
      if (acc) begin
        if (fq.size() == 0) fmode = m;
        fq.push_back(d);
        if (l || fq.size() == MB) begin
          res = fmode ? '0 : '1;
          foreach (fq[i]) res = fmode ? (res | fq[i]) : (res & fq[i]);
          m_data  = res;
          m_pop   = $countones(res);
          m_beats = fq.size();
          m_mode  = fmode;
          m_trunc = !l;
          fq.delete();
          closed  = 1;
        end
      end
      if (closed) m_valid = 1;
      else if (pop) m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_pop",   32'(out_pop),   32'(m_pop));
    check("out_beats", 32'(out_beats), 32'(m_beats));
    check("out_mode",  32'(out_mode),  32'(m_mode));
    check("out_trunc", 32'(out_trunc), 32'(m_trunc));
    check("busy",      32'(busy),      32'(fq.size() != 0));
  endtask

  // One clock cycle: drive at the falling edge, check in_ready, advance, check outputs.
  task automatic step(input bit r, input bit iv, input logic [W-1:0] d,
                      input bit m, input bit l, input bit ordy);
    rst = r; in_valid = iv; in_data = d; in_mode = m; in_last = l; out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!r && (!m_valid || ordy)));
    model_step(r, iv, d, m, l, ordy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    m_valid = 0; m_data = '0; m_pop = 0; m_beats = 0; m_mode = 0; m_trunc = 0; fmode = 0;
    @(negedge clk);

    // Reset state
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 1, 8'hFF, 1, 1, 1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_data",  32'(out_data),  32'd0);

    // OR frame, result held with out_ready low
    step(0, 1, 8'h01, 1, 0, 0);
    step(0, 1, 8'h10, 1, 0, 0);
    check("or_not_yet_valid", 32'(out_valid), 32'd0);
    step(0, 1, 8'h80, 1, 1, 0);
    check("or_data",  32'(out_data),  32'h91);
    check("or_pop",   32'(out_pop),   32'd3);
    check("or_beats", 32'(out_beats), 32'd3);
    check("or_mode",  32'(out_mode),  32'd1);
    check("or_trunc", 32'(out_trunc), 32'd0);

    // Back-pressure: next beats are refused
    step(0, 1, 8'h55, 0, 0, 0);
    check("bp_busy", 32'(busy), 32'd0);
    step(0, 1, 8'h55, 0, 0, 0);
    check("bp_hold", 32'(out_data), 32'h91);

    // AND frame with mode toggling after the first beat
    step(0, 1, 8'hFF, 0, 0, 1);
    step(0, 1, 8'hF0, 1, 0, 1);
    step(0, 1, 8'h3C, 1, 1, 1);
    check("and_data", 32'(out_data), 32'h30);
    check("and_pop",  32'(out_pop),  32'd2);
    check("and_mode", 32'(out_mode), 32'd0);

    // Stall, then pop and load on the same edge with a single-beat frame
    step(0, 1, 8'h77, 0, 0, 0);
    step(0, 1, 8'hA5, 1, 1, 1);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_data",  32'(out_data),  32'hA5);
    check("b2b_beats", 32'(out_beats), 32'd1);
    check("b2b_pop",   32'(out_pop),   32'd4);
    check("b2b_busy",  32'(busy),      32'd0);
    step(0, 0, 8'h00, 0, 0, 1);
    check("pop_clear", 32'(out_valid), 32'd0);

    // Truncation at MAX_BEATS, then a 1-beat frame closed by last
    for (int i = 0; i < MB + 1; i++) begin
      step(0, 1, 8'h00, 1, (i == MB), 1);
      if (i == MB - 1) begin
        check("trunc_beats", 32'(out_beats), 32'(MB));
        check("trunc_flag",  32'(out_trunc), 32'd1);
        check("trunc_busy",  32'(busy),      32'd0);
      end
    end
    check("after_trunc_beats", 32'(out_beats), 32'd1);
    check("after_trunc_flag",  32'(out_trunc), 32'd0);
    step(0, 0, 8'h00, 0, 0, 1);

    // Reset mid-frame, then reset with a held result
    step(0, 1, 8'h03, 0, 0, 1);
    step(0, 1, 8'h07, 0, 0, 1);
    step(1, 0, 8'h00, 0, 0, 1);
    check("midrst_busy",  32'(busy),      32'd0);
    check("midrst_beats", 32'(out_beats), 32'd0);
    step(0, 1, 8'hAA, 1, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    check("heldrst_valid", 32'(out_valid), 32'd0);
    check("heldrst_data",  32'(out_data),  32'd0);
    step(0, 1, 8'h0F, 0, 1, 1);
    check("fresh_data",  32'(out_data),  32'h0F);
    check("fresh_beats", 32'(out_beats), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom),
           1'($urandom),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
